// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES widths, inverse cipher FSM state type and the inverse S-box table.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = AES_STATE_W / AES_BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element 0 sits in the most significant byte, so row 0 of the table reads left to right.
  localparam logic [0:255][AES_BYTE_W-1:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [AES_BYTE_W-1:0] inv_sbox_lookup(input logic [AES_BYTE_W-1:0] a);
    return INV_SBOX[a];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box, one byte in, one byte out.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] addr,
  output logic [AES_BYTE_W-1:0] data
);

  assign data = inv_sbox_lookup(addr);

endmodule

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - InvSubBytes over a 128-bit state, BPC bytes per cycle, valid/ready on both sides.
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   IN_valid,
  output logic                   IN_ready,
  input  logic [AES_STATE_W-1:0] IN_state,
  output logic                   OUT_valid,
  input  logic                   OUT_ready,
  output logic [AES_STATE_W-1:0] OUT_state
);

  localparam int N     = AES_NBYTES / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes: BPC must be 1, 2, 4, 8 or 16");
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] src_q, src_d;
  logic [AES_STATE_W-1:0] res_q, res_d;
  logic                   last_step;

  logic [BPC-1:0][AES_BYTE_W-1:0] lane_addr;
  logic [BPC-1:0][AES_BYTE_W-1:0] lane_data;

  for (genvar j = 0; j < BPC; j++) begin : g_lane
    inv_sbox u_inv_sbox (
      .addr (lane_addr[j]),
      .data (lane_data[j])
    );
  end

  assign last_step = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (IN_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (OUT_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte k belongs to step k/BPC and to lane k%BPC of that step.
  always_comb begin
    lane_addr = '0;
    for (int k = 0; k < AES_NBYTES; k++) begin
      if (CNT_W'(k / BPC) == cnt_q) begin
        lane_addr[k % BPC] = src_q[AES_STATE_W-1-AES_BYTE_W*k -: AES_BYTE_W];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    src_d = src_q;
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (IN_valid) begin
          src_d = IN_state;
          cnt_d = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int k = 0; k < AES_NBYTES; k++) begin
          if (CNT_W'(k / BPC) == cnt_q) begin
            res_d[AES_STATE_W-1-AES_BYTE_W*k -: AES_BYTE_W] = lane_data[k % BPC];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    IN_ready  = (state_q == IDLE);
    OUT_valid = (state_q == DONE);
  end

  assign OUT_state = res_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb/tb_inv_sub_bytes.sv - self-checking bench for inv_sub_bytes over BPC = 4, 16, 1, 2, 8.
module tb_inv_sub_bytes;

  localparam int NI = 5;

  function automatic int bpc_of(input int i);
    case (i)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      3:       return 2;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n   [NI];
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_state  [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inv_sub_bytes #(.BPC(bpc_of(g))) u_dut (
      .clk       (clk),
      .reset_n   (reset_n[g]),
      .IN_valid  (in_valid[g]),
      .IN_ready  (in_ready[g]),
      .IN_state  (in_state[g]),
      .OUT_valid (out_valid[g]),
      .OUT_ready (out_ready[g]),
      .OUT_state (out_state[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] sbox_of(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_block(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_m[x[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one block while IDLE, waits for DONE, then drains it with a single OUT_ready pulse.
  task automatic do_block(input int i, input logic [127:0] din, output int lat, output logic [127:0] dout);
    @(negedge clk);
    check("in_ready_idle", 128'(in_ready[i]), 128'd1);
    in_valid[i] = 1'b1;
    in_state[i] = din;
    @(negedge clk);
    in_valid[i] = 1'b0;
    lat = 0;
    while (!out_valid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    dout = out_state[i];
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  task automatic blk_check(input int i, input string tag, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    logic [127:0] dout;
    do_block(i, din, lat, dout);
    check({tag, "_latency"}, 128'(lat), 128'(16 / bpc_of(i)));
    check({tag, "_data"}, dout, exp);
  endtask

  task automatic back_to_back(input int i);
    logic [127:0] blk [4];
    int sent = 0, got = 0, last = 0;
    for (int b = 0; b < 4; b++) blk[b] = rand_block();
    out_ready[i] = 1'b1;
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid[i]) begin
        check("b2b_data", out_state[i], inv_block(blk[got]));
        got++;
      end
      if (in_ready[i]) begin
        if (sent < 4) begin
          if (sent > 0) check("b2b_interval", 128'(c - last), 128'(16 / bpc_of(i) + 2));
          last = c;
          in_valid[i] = 1'b1;
          in_state[i] = blk[sent];
          sent++;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
    end
    check("b2b_count", 128'(got), 128'd4);
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] d1, d2, hold, din, exp;
    int lat;
    bit seen;

    for (int x = 0; x < 256; x++) begin
      sbox_m[x] = sbox_of(8'(x));
      inv_m[sbox_m[x]] = 8'(x);
    end

    for (int i = 0; i < NI; i++) begin
      reset_n[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_state[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_out_valid", 128'(out_valid[i]), 128'd0);
      check("reset_out_state", out_state[i], 128'd0);
      check("reset_in_ready", 128'(in_ready[i]), 128'd1);
      reset_n[i] = 1'b1;
    end

    blk_check(0, "fips_vec_bpc4", 128'h637C777BF26B6FC53001672BFED7AB76,
              128'h000102030405060708090A0B0C0D0E0F);
    blk_check(1, "all63_bpc16", {16{8'h63}}, {16{8'h00}});
    blk_check(1, "all16_bpc16", {16{8'h16}}, {16{8'hFF}});
    blk_check(1, "allED_bpc16", {16{8'hED}}, {16{8'h53}});

    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 3; r++) begin
        din = rand_block();
        blk_check(i, "random", din, inv_block(din));
      end
    end

    // Exhaustive byte coverage plus the SubBytes round trip on the narrow and wide configurations.
    for (int i = 2; i < NI; i++) begin
      for (int b = 0; b < 16; b++) begin
        for (int k = 0; k < 16; k++) din[127-8*k -: 8] = 8'(16 * b + k);
        blk_check(i, "exhaustive", din, inv_block(din));
        exp = din;
        for (int k = 0; k < 16; k++) din[127-8*k -: 8] = sbox_m[16 * b + k];
        blk_check(i, "round_trip", din, exp);
      end
    end

    d1 = rand_block();
    d2 = rand_block();
    @(negedge clk);
    in_valid[0] = 1'b1; in_state[0] = d1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 128'(lat), 128'd4);
    hold = inv_block(d1);
    in_valid[0] = 1'b1; in_state[0] = d2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
      check("bp_out_state", out_state[0], hold);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_release_valid", 128'(out_valid[0]), 128'd0);
    check("bp_release_ready", 128'(in_ready[0]), 128'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid[0];
    end
    check("bp_no_phantom", 128'(seen), 128'd0);
    check("bp_idle_keeps_result", out_state[0], hold);

    @(negedge clk);
    in_valid[0] = 1'b1; in_state[0] = rand_block();
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    reset_n[0] = 1'b0;
    @(negedge clk);
    reset_n[0] = 1'b1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst_out_state", out_state[0], 128'd0);
    check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid[0];
    end
    check("midrst_no_output", 128'(seen), 128'd0);
    din = rand_block();
    blk_check(0, "after_reset", din, inv_block(din));

    back_to_back(3);
    back_to_back(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
